mssb_if: RTL and testbench
==========================

// Module: mssb_if
// PURPOSE
//  OPB-slave built-in self-test for the MSSB serial link. A start write makes it send N pattern bytes on
//  MSSB_TX (UART 8N1). Bytes arriving on MSSB_RX (normally looped back) are checked against the same
//  pattern. Received/error byte counts and a pass/fail status are readable over OPB.
// PARAMETERS
//  CLKS_PER_BIT  16    OPB_CLK cycles per serial bit (TX and RX)
//  RX_TIMEOUT    4096  idle cycles after TX completes before an incomplete RX run is ended
// PORTS
//  OPB_CLK     in   1   sole clock, rising edge
//  OPB_RST     in   1   reset, asynchronous, active-high
//  OPB_ADDR    in   32  register address; only [3:0] decoded
//  OPB_DI      in   32  write data
//  MSSB_IF_RE  in   1   read strobe, one cycle
//  MSSB_IF_WE  in   1   write strobe, one cycle
//  OPB_DO      out  32  read data, registered
//  MSSB_TX     out  1   serial out, idle high
//  MSSB_RX     in   1   serial in, asynchronous; double-flop synchronised
// BEHAVIOUR
//  Registers (OPB_ADDR[3:0]):
//   0 CONFIG  W: [31]=start (self-clearing), [19:0]=trans_bytes. R: [31]=busy, [19:0]=trans_bytes.
//   1 STATUS  R: [1:0]: 00 idle/busy, 01 done with no error, 11 done with error.
//   2 RECV    R: [19:0]=bytes received since start.
//   3 ERROR   R: [19:0]=bytes received with mismatch or bad stop bit.
//   Unused bits read 0. Other addresses read 0; writes to them are ignored.
//  Reads: OPB_DO loads the selected register on the clock edge where MSSB_IF_RE=1. It holds until the next read.
//  Reset: OPB_DO=0, MSSB_TX=1, all registers/counters=0, FSM=IDLE.
//  Start: WE to addr 0 with DI[31]=1 while not busy. Latches trans_bytes, clears RECV/ERROR/STATUS,
//   sets busy next cycle. Start while busy is ignored. DI[31]=0 only updates trans_bytes when idle.
//  trans_bytes=0: STATUS=01 on the cycle after start; nothing transmitted.
//  Pattern: byte k (k=0..N-1) = k[7:0]. Sent LSB first: start(0), 8 data bits, stop(1), each bit
//   CLKS_PER_BIT cycles, back-to-back, no inter-byte gap.
//  TX FSM: IDLE -> START -> DATA(x8) -> STOP -> (next byte ? START : IDLE). 20-bit byte counter, no wrap.
//  RX: falling edge in idle starts a frame. Confirm start at mid-bit, sample data at mid-bit, check stop at
//   mid-bit. Every frame increments RECV. The expected value is RECV[7:0] before the increment. ERROR
//   increments on data mismatch or stop=0; a byte counts as at most one error.
//  Completion: when RECV==trans_bytes, or RX_TIMEOUT cycles after TX IDLE with no new start edge.
//   STATUS=01 if ERROR==0 and RECV==trans_bytes, else 11. Busy clears. RX ignores frames while not busy.
//  Reset mid-run aborts immediately to the reset state. Counters saturate at 20'hFFFFF.
// CONFIGURATION
//  MSSB_ERR_INJECT_EN defined: CONFIG[30] is writable/readable inject flag. When it is set, each byte with
//   k[3:0]==4'hF goes out with data bit 0 inverted, and expected ERROR = floor(N/16).
//  Not defined: CONFIG[30] reads 0, writes are ignored, and no corruption is possible.
// TESTING
//  1 Loopback TX->RX, write 0:{1,11'b0,20'h30}, wait 1 ms -> STATUS 00000001, RECV 00000030, ERROR 0.
//  2 Loopback, trans_bytes=0 + start -> STATUS 01 next cycle, MSSB_TX stays 1, RECV 0.
//  3 RX tied high, N=4 -> after TX done + RX_TIMEOUT: STATUS 00000003, RECV 0, ERROR 0.
//  4 Start with N=0x100; a second start mid-run is ignored -> RECV 0x100, STATUS 01.
//  5 OPB_RST asserted mid-frame -> MSSB_TX=1, OPB_DO=0, all regs 0 asynchronously; restart passes.
//  6 MSSB_ERR_INJECT_EN, CONFIG[30]=1, N=0x30 -> RECV 0x30, ERROR 3, STATUS 3.

Source files
------------

// File: rtl/mssb_if.sv
// OPB-slave self-test for the MSSB serial link: sends N pattern bytes (byte k = k[7:0]) as UART 8N1
// on MSSB_TX and checks the bytes that come back on MSSB_RX, counting received and bad bytes.
// Optional feature macro: MSSB_ERR_INJECT_EN (CONFIG[30] corrupts data bit 0 of bytes with k[3:0]==4'hF).
module mssb_if #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RX_TIMEOUT   = 4096
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [31:0] OPB_ADDR,
    input  logic [31:0] OPB_DI,
    input  logic        MSSB_IF_RE,
    input  logic        MSSB_IF_WE,
    output logic [31:0] OPB_DO,
    output logic        MSSB_TX,
    input  logic        MSSB_RX
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(RX_TIMEOUT - 1);
    localparam logic [19:0]   CNT_MAX   = 20'hFFFFF;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Register file state
    logic [19:0] trans_q, trans_d;
    logic [19:0] recv_q, recv_d;
    logic [19:0] err_q, err_d;
    logic [1:0]  status_q, status_d;
    logic        busy_q, busy_d;
    logic        inject_q;

    // TX state
    tx_state_t   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [19:0] tx_byte_q;
    logic [7:0]  tx_sh_q;

    // RX state
    rx_state_t   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        rx_done_q, rx_bad_q;

    logic [TW-1:0] to_cnt_q;

    logic cfg_wr, tx_idle, rx_idle, idle, start_acc, tx_go, timeout;
    logic unused_ok;

    assign unused_ok = ^{OPB_ADDR[31:4], OPB_DI[30:20]};

    assign cfg_wr    = MSSB_IF_WE && (OPB_ADDR[3:0] == 4'd0);
    assign tx_idle   = (tx_state_q == TX_IDLE);
    assign rx_idle   = (rx_state_q == RX_IDLE);
    // A new run may only start once the transmitter has fully drained its last stop bit.
    assign idle      = !busy_q && tx_idle;
    assign start_acc = cfg_wr && OPB_DI[31] && idle;
    assign tx_go     = start_acc && (OPB_DI[19:0] != 20'd0);
    assign timeout   = (to_cnt_q == TO_LAST);

    function automatic logic [7:0] pattern(input logic [19:0] k, input logic inj);
        return k[7:0] ^ {7'd0, inj && (k[3:0] == 4'hF)};
    endfunction

    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == CNT_MAX) ? v : v + 20'd1;
    endfunction

`ifdef MSSB_ERR_INJECT_EN
    // Inject flag is configuration: writable only between runs, like trans_bytes.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST)
            inject_q <= 1'b0;
        else if (cfg_wr && idle)
            inject_q <= OPB_DI[30];
    end
`else
    assign inject_q = 1'b0;
`endif

    // Next-state for configuration, counters, status and busy; completion is judged on post-update counts.
    always_comb begin
        trans_d  = trans_q;
        recv_d   = recv_q;
        err_d    = err_q;
        status_d = status_q;
        busy_d   = busy_q;
        if (cfg_wr && idle)
            trans_d = OPB_DI[19:0];
        if (start_acc) begin
            recv_d = 20'd0;
            err_d  = 20'd0;
            if (OPB_DI[19:0] == 20'd0) begin
                status_d = 2'b01;
            end else begin
                status_d = 2'b00;
                busy_d   = 1'b1;
            end
        end else if (busy_q) begin
            if (rx_done_q) begin
                recv_d = sat_inc(recv_q);
                if (rx_bad_q)
                    err_d = sat_inc(err_q);
            end
            if ((recv_d == trans_q) || timeout) begin
                busy_d   = 1'b0;
                status_d = ((err_d == 20'd0) && (recv_d == trans_q)) ? 2'b01 : 2'b11;
            end
        end
    end

    // Register file update
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            trans_q  <= 20'd0;
            recv_q   <= 20'd0;
            err_q    <= 20'd0;
            status_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            trans_q  <= trans_d;
            recv_q   <= recv_d;
            err_q    <= err_d;
            status_q <= status_d;
            busy_q   <= busy_d;
        end
    end

    // Idle-line timer: runs only while busy with TX finished and no RX frame in progress.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST)
            to_cnt_q <= '0;
        else if (busy_q && tx_idle && rx_idle)
            to_cnt_q <= timeout ? to_cnt_q : to_cnt_q + 1'b1;
        else
            to_cnt_q <= '0;
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            OPB_DO <= 32'd0;
        end else if (MSSB_IF_RE) begin
            case (OPB_ADDR[3:0])
                4'd0:    OPB_DO <= {!idle, inject_q, 10'd0, trans_q};
                4'd1:    OPB_DO <= {30'd0, status_q};
                4'd2:    OPB_DO <= {12'd0, recv_q};
                4'd3:    OPB_DO <= {12'd0, err_q};
                default: OPB_DO <= 32'd0;
            endcase
        end
    end

    // TX frame sequencer: start, 8 data bits LSB first, stop, back-to-back bytes.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_byte_q  <= 20'd0;
            tx_sh_q    <= 8'd0;
            MSSB_TX    <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    MSSB_TX <= 1'b1;
                    if (tx_go) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= '0;
                        tx_byte_q  <= 20'd0;
                        tx_sh_q    <= 8'd0;  // byte 0 is never a corruption target
                        MSSB_TX    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= 3'd0;
                        MSSB_TX    <= tx_sh_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            MSSB_TX    <= 1'b1;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            MSSB_TX  <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (({1'b0, tx_byte_q} + 21'd1) < {1'b0, trans_q}) begin
                            tx_state_q <= TX_START;
                            tx_byte_q  <= tx_byte_q + 20'd1;
                            tx_sh_q    <= pattern(tx_byte_q + 20'd1, inject_q);
                            MSSB_TX    <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus previous-sample register for start-edge detection.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= MSSB_RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX frame checker: mid-bit sampling; one done pulse per frame with a single bad flag.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_done_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_bad_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (busy_q && rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7)
                            rx_state_q <= RX_STOP;
                        else
                            rx_bit_q <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_done_q  <= 1'b1;
                        rx_bad_q   <= (rx_sh_q != recv_q[7:0]) || !rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mssb_if.sv
// Bench for mssb_if: directed runs, a per-cycle TX waveform model and a run-level outcome model.
// Latency: reads return on the cycle after the RE edge.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_mssb_if;

    localparam int CPB = 16;
    localparam int TOUT = 4096;
`ifdef MSSB_ERR_INJECT_EN
    localparam bit INJ_BUILT = 1'b1;
`else
    localparam bit INJ_BUILT = 1'b0;
`endif

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST = 1'b1;
    logic [31:0] OPB_ADDR = 32'd0;
    logic [31:0] OPB_DI = 32'd0;
    logic        MSSB_IF_RE = 1'b0;
    logic        MSSB_IF_WE = 1'b0;
    logic [31:0] OPB_DO;
    logic        MSSB_TX;
    logic        loop_en = 1'b1;
    logic        rx_lvl = 1'b1;
    logic        MSSB_RX;

    assign MSSB_RX = loop_en ? MSSB_TX : rx_lvl;

    mssb_if #(.CLKS_PER_BIT(CPB), .RX_TIMEOUT(TOUT)) dut (
        .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
        .MSSB_IF_RE(MSSB_IF_RE), .MSSB_IF_WE(MSSB_IF_WE), .OPB_DO(OPB_DO),
        .MSSB_TX(MSSB_TX), .MSSB_RX(MSSB_RX)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint start_cyc = 0;
    int     run_n = 0;
    bit     run_inj = 1'b0;
    bit     tx_chk_en = 1'b0;

    always @(posedge OPB_CLK) cyc++;

    // Expected serial level t cycles after the accepted start edge.
    function automatic logic exp_tx(longint t, int n, bit inj);
        longint b;
        int ph;
        logic [7:0] byt;
        if (t >= longint'(n) * 10 * CPB) return 1'b1;
        b  = t / (10 * CPB);
        ph = int'((t % (10 * CPB)) / CPB);
        if (ph == 0) return 1'b0;
        if (ph == 9) return 1'b1;
        byt = b[7:0];
        if (inj && (b[3:0] == 4'hF)) byt[0] = ~byt[0];
        return byt[ph-1];
    endfunction

    // Cycle-by-cycle TX waveform compare.
    always @(negedge OPB_CLK) begin : tx_cmp
        logic e;
        if (tx_chk_en && !OPB_RST) begin
            e = exp_tx(cyc - start_cyc, run_n, run_inj);
            checks++;
            if (MSSB_TX !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL tx_wave t=%0d got %b exp %b", cyc - start_cyc, MSSB_TX, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge OPB_CLK);
        OPB_ADDR = {28'd0, a};
        OPB_DI = d;
        MSSB_IF_WE = 1'b1;
        @(posedge OPB_CLK);
        #1 MSSB_IF_WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge OPB_CLK);
        OPB_ADDR = {28'd0, a};
        MSSB_IF_RE = 1'b1;
        @(posedge OPB_CLK);
        #1 MSSB_IF_RE = 1'b0;
        d = OPB_DO;
    endtask

    task automatic start_run(input int n, input bit inj);
        wr(4'd0, {1'b1, inj, 10'd0, n[19:0]});
        start_cyc = cyc;
        run_n = n;
        run_inj = inj && INJ_BUILT;
        tx_chk_en = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [31:0] v;
        int i;
        v = 32'hFFFF_FFFF;
        for (i = 0; i < budget; i++) begin
            rd(4'd0, v);
            if (!v[31]) break;
        end
        if (v[31]) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got busy exp idle within %0d reads", name, budget);
        end
        tx_chk_en = 1'b0;
    endtask

    // Run-outcome model and register compare; returns what was read for literal pinning.
    task automatic check_run(input string name, input int n, input bit loop, input bit inj,
                             output logic [31:0] st, output logic [31:0] rc, output logic [31:0] er);
        int e_rc, e_er, e_st;
        if (n == 0) begin
            e_rc = 0; e_er = 0; e_st = 1;
        end else if (loop) begin
            e_rc = n;
            e_er = (inj && INJ_BUILT) ? n / 16 : 0;
            e_st = (e_er == 0) ? 1 : 3;
        end else begin
            e_rc = 0; e_er = 0; e_st = 3;
        end
        rd(4'd1, st); chk({name, "_status"}, st, e_st);
        rd(4'd2, rc); chk({name, "_recv"}, rc, e_rc);
        rd(4'd3, er); chk({name, "_error"}, er, e_er);
    endtask

    initial begin
        logic [31:0] v, st, rc, er;

        // Reset state
        repeat (3) @(posedge OPB_CLK);
        #1;
        chk("rst_tx", {31'd0, MSSB_TX}, 32'd1);
        chk("rst_do", OPB_DO, 32'd0);
        @(negedge OPB_CLK) OPB_RST = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[3:0], v);
            chk($sformatf("rst_reg%0d", a), v, 32'd0);
        end

        // Config-only write, unused address, inject bit handling
        wr(4'd0, 32'h4001_2345);
        rd(4'd0, v);
        chk("cfg_write", v, INJ_BUILT ? 32'h4001_2345 : 32'h0001_2345);
        wr(4'd4, 32'hFFFF_FFFF);
        rd(4'd5, v);
        chk("unused_addr", v, 32'd0);
        wr(4'd0, 32'h0000_0000);

        // Test 1: loopback, N=0x30
        start_run(32'h30, 1'b0);
        wait_idle("t1", 12000);
        check_run("t1", 32'h30, 1'b1, 1'b0, st, rc, er);
        chk("t1_status_lit", st, 32'h1);
        chk("t1_recv_lit", rc, 32'h30);

        // Test 2: N=0 completes next cycle with no transmission
        start_run(0, 1'b0);
        rd(4'd1, v);
        chk("t2_status_next", v, 32'h1);
        repeat (20) @(posedge OPB_CLK);
        tx_chk_en = 1'b0;
        rd(4'd2, v);
        chk("t2_recv", v, 32'd0);

        // Test 3: RX tied high, N=4 ends by timeout
        loop_en = 1'b0;
        start_run(4, 1'b0);
        wait_idle("t3", 6000);
        check_run("t3", 4, 1'b0, 1'b0, st, rc, er);
        chk("t3_status_lit", st, 32'h3);
        loop_en = 1'b1;

        // Test 4: N=0x100 with an ignored second start
        start_run(32'h100, 1'b0);
        repeat (2000) @(posedge OPB_CLK);
        wr(4'd0, 32'h8000_0005);
        wait_idle("t4", 45000);
        rd(4'd0, v);
        chk("t4_cfg_kept", v, 32'h0000_0100);
        check_run("t4", 32'h100, 1'b1, 1'b0, st, rc, er);
        chk("t4_recv_lit", rc, 32'h100);

        // Test 5: reset mid-frame, then a clean restart
        start_run(32'h30, 1'b0);
        repeat (810) @(posedge OPB_CLK);
        rd(4'd0, v);
        chk("t5_busy", v, 32'h8000_0030);
        tx_chk_en = 1'b0;
        @(negedge OPB_CLK);
        #2 OPB_RST = 1'b1;
        #1;
        chk("t5_async_tx", {31'd0, MSSB_TX}, 32'd1);
        chk("t5_async_do", OPB_DO, 32'd0);
        repeat (2) @(posedge OPB_CLK);
        @(negedge OPB_CLK) OPB_RST = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[3:0], v);
            chk($sformatf("t5_reg%0d", a), v, 32'd0);
        end
        start_run(8, 1'b0);
        wait_idle("t5r", 3000);
        check_run("t5r", 8, 1'b1, 1'b0, st, rc, er);

        // Test 6: error injection (corruption only exists in the inject build)
        start_run(32'h30, 1'b1);
        wait_idle("t6", 12000);
        check_run("t6", 32'h30, 1'b1, 1'b1, st, rc, er);
        chk("t6_error_lit", er, INJ_BUILT ? 32'h3 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
